tx_hs_burst_scheduler: RTL and testbench

Arbitrates two byte-stream requesters onto the single HS transmit lane FSM and sequences each HS burst end to end:
- raises the lane Enable;
- feeds payload bytes on every lane READY cycle;
- marks the last byte with END_DATA;
- holds Enable through HS-TRAIL;
- enforces a minimum LP gap before the next burst.

It sits between packet sources (e.g. the two virtual-channel packers) and the HS lane FSM, in the byte/DDR clock domain.

---
 rtl/mipi_tx_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/tx_hs_burst_scheduler.sv | 143 ++++++++++++++
 tb/tb_tx_hs_burst_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_tx_pkg.sv
// Shared MIPI TX definitions: HS lane state encodings, scheduler states, byte constants.
package mipi_tx_pkg;

  // Must match the encoding driven by the HS lane FSM on TX_HS_STATE.
  typedef enum logic [2:0] {
    LANE_STOP  = 3'd0,
    LANE_ZERO  = 3'd1,
    LANE_SYNC  = 3'd2,
    LANE_DATA  = 3'd3,
    LANE_TRAIL = 3'd4
  } hs_lane_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_WAIT_STOP,
    S_GAP
  } sched_state_e;

  localparam logic [7:0] SYNC_BYTE  = 8'h1D;
  localparam logic [7:0] TRAIL_FILL = 8'h00;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr remembers the last granted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to "last granted 1" so the first contended grant goes to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b1;
    end else if (update) begin
      ptr <= grant[1];
    end
  end

endmodule

// File: rtl/tx_hs_burst_scheduler.sv
// Arbitrates two byte-stream requesters onto the HS lane and sequences each burst
// from Enable through payload, END_DATA and TRAIL to a minimum LP gap.
module tx_hs_burst_scheduler
  import mipi_tx_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int T_LP_GAP = 8
) (
  input  logic             TX_DDR_clk,
  input  logic             TX_rst_n,
  input  logic [1:0]       REQ,
  input  logic [LEN_W-1:0] REQ_LEN0,
  input  logic [LEN_W-1:0] REQ_LEN1,
  input  logic [7:0]       DATA0,
  input  logic [7:0]       DATA1,
  input  logic [1:0]       DATA_VALID,
  input  logic             TX_HS_READY,
  input  logic [2:0]       TX_HS_STATE,
  output logic             HS_ENABLE,
  output logic [7:0]       TX_BYTE_DATA,
  output logic             TX_HS_END_DATA,
  output logic [1:0]       GRANT,
  output logic [1:0]       DATA_ACK,
  output logic [1:0]       DONE,
  output logic             UNDERRUN,
  output logic             BUSY
);

  localparam int GAP_W = $clog2(T_LP_GAP + 1);

  sched_state_e     state, state_nx;
  logic [1:0]       grant_q, grant_nx;
  logic [LEN_W-1:0] rem, rem_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic [1:0]       done_zl, done_zl_nx;

  logic [1:0]       arb_req, arb_gnt;
  logic             arb_update;
  logic             ptr_unused;
  logic [LEN_W-1:0] len_sel;
  logic [7:0]       byte_sel;
  logic             valid_sel;

  // A requester whose zero-length DONE is pulsing still holds REQ this cycle;
  // masking it stops the same request being granted twice.
  assign arb_req = REQ & ~done_zl;

  rr_arb2 u_arb (
    .clk    (TX_DDR_clk),
    .rst_n  (TX_rst_n),
    .req    (arb_req),
    .update (arb_update),
    .grant  (arb_gnt),
    .ptr    (ptr_unused)
  );

  assign len_sel   = arb_gnt[1] ? REQ_LEN1 : REQ_LEN0;
  assign byte_sel  = grant_q[1] ? DATA1 : DATA0;
  assign valid_sel = grant_q[1] ? DATA_VALID[1] : DATA_VALID[0];

  assign GRANT = grant_q;
  assign BUSY  = (state != S_IDLE);

  always_comb begin
    state_nx       = state;
    grant_nx       = grant_q;
    rem_nx         = rem;
    gap_nx         = gap_cnt;
    done_zl_nx     = 2'b00;
    arb_update     = 1'b0;
    HS_ENABLE      = 1'b0;
    TX_BYTE_DATA   = TRAIL_FILL;
    TX_HS_END_DATA = 1'b0;
    DATA_ACK       = 2'b00;
    DONE           = done_zl;
    UNDERRUN       = 1'b0;
    case (state)
      S_IDLE: begin
        if (|arb_req) begin
          arb_update = 1'b1;
          if (len_sel == '0) begin
            done_zl_nx = arb_gnt;
          end else begin
            grant_nx = arb_gnt;
            rem_nx   = len_sel;
            state_nx = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        HS_ENABLE = 1'b1;
        if (TX_HS_READY) begin
          // The HS stream cannot stall: a missing byte is sent as fill and still counted.
          DATA_ACK     = grant_q;
          TX_BYTE_DATA = valid_sel ? byte_sel : TRAIL_FILL;
          UNDERRUN     = !valid_sel;
          if (rem != '0) begin
            rem_nx = rem - LEN_W'(1);
          end
          if (rem == LEN_W'(1)) begin
            TX_HS_END_DATA = 1'b1;
            state_nx       = S_WAIT_STOP;
          end
        end
      end
      S_WAIT_STOP: begin
        // Combinational so Enable is already low in the first STOP cycle.
        HS_ENABLE = (TX_HS_STATE != LANE_STOP);
        if (TX_HS_STATE == LANE_STOP) begin
          DONE     = grant_q;
          grant_nx = 2'b00;
          gap_nx   = GAP_W'(T_LP_GAP - 1);
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          state_nx = S_IDLE;
        end else begin
          gap_nx = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge TX_DDR_clk or negedge TX_rst_n) begin
    if (!TX_rst_n) begin
      state   <= S_IDLE;
      grant_q <= 2'b00;
      rem     <= '0;
      gap_cnt <= '0;
      done_zl <= 2'b00;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      rem     <= rem_nx;
      gap_cnt <= gap_nx;
      done_zl <= done_zl_nx;
    end
  end

endmodule

// File: tb/tb_tx_hs_burst_scheduler.sv
// Directed bench for tx_hs_burst_scheduler with a small HS lane model (T_HS_ZERO=4, T_HS_TRAIL=4).
module tb_tx_hs_burst_scheduler;
  import mipi_tx_pkg::*;

  localparam int LEN_W    = 4;
  localparam int T_LP_GAP = 8;
  localparam int T_ZERO   = 4;
  localparam int T_TRAIL  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [LEN_W-1:0] len0, len1;
  logic [7:0]       data0, data1;
  logic [1:0]       dvalid;
  logic             ready;
  logic [2:0]       lane_st = 3'd0;
  int               lane_cnt = 0;

  logic             hs_en, end_o, under, busy;
  logic [7:0]       byte_o;
  logic [1:0]       grant, ack, done;

  tx_hs_burst_scheduler #(.LEN_W(LEN_W), .T_LP_GAP(T_LP_GAP)) dut (
    .TX_DDR_clk     (clk),
    .TX_rst_n       (rst_n),
    .REQ            (req),
    .REQ_LEN0       (len0),
    .REQ_LEN1       (len1),
    .DATA0          (data0),
    .DATA1          (data1),
    .DATA_VALID     (dvalid),
    .TX_HS_READY    (ready),
    .TX_HS_STATE    (lane_st),
    .HS_ENABLE      (hs_en),
    .TX_BYTE_DATA   (byte_o),
    .TX_HS_END_DATA (end_o),
    .GRANT          (grant),
    .DATA_ACK       (ack),
    .DONE           (done),
    .UNDERRUN       (under),
    .BUSY           (busy)
  );

  always #5 clk = ~clk;

  // Lane model: STOP -> ZERO(T_ZERO) -> SYNC -> DATA (READY) -> TRAIL(T_TRAIL) -> STOP
  always @(posedge clk) begin
    case (lane_st)
      LANE_STOP:  if (hs_en) begin lane_st <= LANE_ZERO; lane_cnt <= T_ZERO - 1; end
      LANE_ZERO:  if (!hs_en) lane_st <= LANE_STOP;
                  else if (lane_cnt == 0) lane_st <= LANE_SYNC;
                  else lane_cnt <= lane_cnt - 1;
      LANE_SYNC:  lane_st <= hs_en ? LANE_DATA : LANE_STOP;
      LANE_DATA:  if (!hs_en || end_o) begin lane_st <= LANE_TRAIL; lane_cnt <= T_TRAIL - 1; end
      LANE_TRAIL: if (lane_cnt == 0) lane_st <= LANE_STOP; else lane_cnt <= lane_cnt - 1;
      default:    lane_st <= LANE_STOP;
    endcase
  end
  assign ready = (lane_st == LANE_DATA);

  int total = 0, bad = 0;
  logic       s_en = 0, s_end = 0, s_under = 0, s_busy = 0;
  logic [7:0] s_byte = 0;
  logic [1:0] s_grant = 0, s_ack = 0, s_done = 0, prev_g = 0;
  int acks0, acks1, ends, end_at, unders, dones0, dones1, en_cnt, drop_at;
  logic [7:0] blog [16];
  int bn;
  logic [1:0] glog [8];
  int gn, lowrun, min_low;
  bit seen_high;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    acks0 = 0; acks1 = 0; ends = 0; end_at = 0; unders = 0;
    dones0 = 0; dones1 = 0; en_cnt = 0; bn = 0;
  endtask

  // Advance one cycle: update requester data after the edge, sample outputs at negedge.
  task automatic step();
    @(posedge clk); #1;
    if (s_ack[0]) data0 = data0 + 8'd1;
    if (s_ack[1]) data1 = data1 + 8'd1;
    if (drop_at != 0) dvalid[0] = ((acks0 + 1) != drop_at);
    @(negedge clk);
    s_en = hs_en; s_byte = byte_o; s_end = end_o; s_grant = grant;
    s_ack = ack; s_done = done; s_under = under; s_busy = busy;
    if (s_ack[0]) acks0++;
    if (s_ack[1]) acks1++;
    if (s_ack != 2'b00 && bn < 16) begin blog[bn] = s_byte; bn++; end
    if (s_end) begin ends++; end_at = acks0 + acks1; end
    if (s_under) unders++;
    if (s_done[0]) dones0++;
    if (s_done[1]) dones1++;
    if (s_en) en_cnt++;
    if (s_grant != 2'b00 && prev_g == 2'b00 && gn < 8) begin glog[gn] = s_grant; gn++; end
    prev_g = s_grant;
    if (!s_en) lowrun++;
    else begin
      if (seen_high && lowrun > 0 && lowrun < min_low) min_low = lowrun;
      seen_high = 1'b1;
      lowrun = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (s_busy && n < 200) begin step(); n++; end
    check("idle_timeout", {31'd0, s_busy}, 32'd0);
  endtask

  task automatic wait_done(input int idx, input int budget);
    int n = 0;
    int d0 = idx ? dones1 : dones0;
    while ((idx ? dones1 : dones0) == d0 && n < budget) begin step(); n++; end
    check("done_timeout", ((idx ? dones1 : dones0) != d0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 0; len0 = 0; len1 = 0; data0 = 0; data1 = 0; dvalid = 0; drop_at = 0;
    gn = 0; lowrun = 0; min_low = 999; seen_high = 0;
    clr();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #2;
    check("reset_outputs", {15'd0, hs_en, byte_o, end_o, grant, ack, done, under, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", {28'd0, s_busy, s_en, s_grant}, 32'd0);

    // Single burst: REQ0, LEN 3, bytes A1..A3 on cycles n+7..n+9, DONE at n+14
    clr();
    len0 = 4'd3; data0 = 8'hA1; dvalid = 2'b01; req = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      logic       e_en, e_ack, e_end;
      logic [7:0] e_byte;
      logic [1:0] e_done, e_grant;
      step();
      e_en    = (k <= 13);
      e_ack   = (k >= 7 && k <= 9);
      e_byte  = e_ack ? 8'(8'hA0 + k - 6) : 8'h00;
      e_end   = (k == 9);
      e_done  = (k == 14) ? 2'b01 : 2'b00;
      e_grant = (k <= 14) ? 2'b01 : 2'b00;
      check($sformatf("single_c%0d", k),
            {16'd0, s_en, s_ack, s_byte, s_end, s_done, s_grant},
            {16'd0, e_en, e_ack ? 2'b01 : 2'b00, e_byte, e_end, e_done, e_grant});
      if (k == 14) req = 2'b00;
    end
    check("single_done_once", dones0, 32'd1);
    check("single_end_once", ends, 32'd1);

    // Underrun: LEN 4, DATA_VALID0 low on the 2nd READY cycle
    wait_idle();
    clr();
    len0 = 4'd4; data0 = 8'hB1; dvalid = 2'b01; drop_at = 2; req = 2'b01;
    wait_done(0, 60);
    req = 2'b00; drop_at = 0; dvalid = 2'b01;
    check("underrun_acks", acks0, 32'd4);
    check("underrun_pulses", unders, 32'd1);
    check("underrun_end_at", end_at, 32'd4);
    check("underrun_bytes", {blog[0], blog[1], blog[2], blog[3]}, 32'hB100B3B4);

    // Zero length on requester 1: DONE at n+1, no Enable
    wait_idle();
    clr();
    len1 = 4'd0; req = 2'b10;
    step();
    check("zl_done_n1", {27'd0, s_done, s_grant, s_en}, {27'd0, 2'b10, 2'b00, 1'b0});
    step();
    check("zl_no_repeat", {30'd0, s_done}, 32'd0);
    req = 2'b00;
    repeat (4) step();
    check("zl_done_count", dones1, 32'd1);
    check("zl_no_enable", en_cnt, 32'd0);

    // Contention: both held, grants alternate starting with requester 0
    clr();
    gn = 0; seen_high = 0; lowrun = 0; min_low = 999;
    len0 = 4'd2; len1 = 4'd2; dvalid = 2'b11; req = 2'b11;
    begin
      int n = 0;
      while ((dones0 + dones1) < 4 && n < 400) begin step(); n++; end
    end
    req = 2'b00;
    check("contention_bursts", dones0 + dones1, 32'd4);
    check("contention_order", {24'd0, glog[0], glog[1], glog[2], glog[3]}, {24'd0, 8'b01_10_01_10});
    check("contention_gap", min_low, T_LP_GAP + 1);
    check("contention_acks", acks0 + acks1, 32'd8);

    // Reset asserted during the 2nd payload byte
    wait_idle();
    clr();
    len0 = 4'd4; data0 = 8'hC1; dvalid = 2'b01; req = 2'b01;
    begin
      int n = 0;
      while (acks0 < 2 && n < 40) begin step(); n++; end
    end
    check("rst_second_byte", acks0, 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {15'd0, hs_en, byte_o, end_o, grant, ack, done, under, busy}, 32'd0);
    req = 2'b00;
    repeat (8) step();
    check("rst_no_done", dones0 + dones1, 32'd0);
    rst_n = 1'b1;
    clr();
    len0 = 4'd1; data0 = 8'hD1; req = 2'b01;
    wait_done(0, 60);
    req = 2'b00;
    check("post_rst_acks", acks0, 32'd1);
    check("post_rst_end", end_at, 32'd1);
    check("post_rst_byte", {24'd0, blog[0]}, 32'h000000D1);

    // Max length: 15 bytes with LEN_W = 4
    wait_idle();
    clr();
    len0 = 4'hF; data0 = 8'h00; dvalid = 2'b01; req = 2'b01;
    wait_done(0, 80);
    req = 2'b00;
    repeat (3) step();
    check("max_acks", acks0, 32'd15);
    check("max_end_at", end_at, 32'd15);
    check("max_end_once", ends, 32'd1);
    check("max_no_underrun", unders, 32'd0);
    check("max_rem_zero", {28'd0, dut.rem}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
